// File: rtl/pipelined_cbya_adder.sv
// rtl/pipelined_cbya_adder.sv - pipelined carry-bypass adder/subtractor, one slice per stage
module pipelined_cbya_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             overflow
);

    localparam int NSTAGES = WIDTH / BLOCK;

    // Whole pipeline moves as one; it only stops when a finished result is being held.
    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < NSTAGES; k++) begin : stg
        // Operand bits still to be summed when entering this stage (slice k and above).
        localparam int IW = WIDTH - k * BLOCK;

        logic                   src_v;
        logic                   src_c;
        logic                   src_amsb;
        logic                   src_bmsb;
        logic [IW-1:0]          src_a;
        logic [IW-1:0]          src_b;
        logic [(k+1)*BLOCK-1:0] sum_d;

        logic [BLOCK-1:0]       slice_s;
        logic                   slice_co;
        logic                   ripple_c;
        logic                   prop_all;

        logic                   vld_q;
        logic                   c_q;
        logic                   amsb_q;
        logic                   bmsb_q;
        logic [(k+1)*BLOCK-1:0] sum_q;

        if (k == 0) begin : g_src
            // Subtraction is folded into operand B and the carry before the first register.
            assign src_v    = in_valid;
            assign src_a    = a;
            assign src_b    = sub ? ~b : b;
            assign src_c    = sub | cin;
            assign src_amsb = a[WIDTH-1];
            assign src_bmsb = sub ? ~b[WIDTH-1] : b[WIDTH-1];
            assign sum_d    = slice_s;
        end else begin : g_src
            assign src_v    = stg[k-1].vld_q;
            assign src_a    = stg[k-1].g_fwd.a_q;
            assign src_b    = stg[k-1].g_fwd.b_q;
            assign src_c    = stg[k-1].c_q;
            assign src_amsb = stg[k-1].amsb_q;
            assign src_bmsb = stg[k-1].bmsb_q;
            assign sum_d    = {slice_s, stg[k-1].sum_q};
        end

        // Ripple-sum this stage's slice; a fully propagating slice bypasses its own ripple carry.
        always_comb begin
            ripple_c = src_c;
            prop_all = 1'b1;
            slice_s  = '0;
            for (int i = 0; i < BLOCK; i++) begin
                slice_s[i] = src_a[i] ^ src_b[i] ^ ripple_c;
                ripple_c   = (src_a[i] & src_b[i]) | (ripple_c & (src_a[i] ^ src_b[i]));
                prop_all   = prop_all & (src_a[i] ^ src_b[i]);
            end
            slice_co = prop_all ? src_c : ripple_c;
        end

        // Stage register; data only loads with a valid operation so bubbles never clobber results.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                c_q    <= 1'b0;
                amsb_q <= 1'b0;
                bmsb_q <= 1'b0;
                sum_q  <= '0;
            end else if (en) begin
                vld_q <= src_v;
                if (src_v) begin
                    c_q    <= slice_co;
                    amsb_q <= src_amsb;
                    bmsb_q <= src_bmsb;
                    sum_q  <= sum_d;
                end
            end
        end

        if (k < NSTAGES - 1) begin : g_fwd
            logic [IW-BLOCK-1:0] a_q;
            logic [IW-BLOCK-1:0] b_q;

            // Carry the not-yet-summed upper operand slices forward to later stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && src_v) begin
                    a_q <= src_a[IW-1:BLOCK];
                    b_q <= src_b[IW-1:BLOCK];
                end
            end
        end
    end

    assign out_valid = stg[NSTAGES-1].vld_q;
    assign r         = stg[NSTAGES-1].sum_q;
    assign cout      = stg[NSTAGES-1].c_q;
    assign overflow  = (stg[NSTAGES-1].amsb_q ^ r[WIDTH-1]) & (stg[NSTAGES-1].bmsb_q ^ r[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_cbya_adder.sv
// tb/tb_pipelined_cbya_adder.sv - self-checking bench for pipelined_cbya_adder
module tb_pipelined_cbya_adder;

    localparam int W  = 32;
    localparam int BK = 8;
    localparam int NS = W / BK;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         cout;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } res_t;

    typedef struct packed {
        logic         acc;
        logic         ret;
        logic         irdy;
        logic         ov;
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } obs_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   acc_cyc_q[$];
    int   lat_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipelined_cbya_adder #(.WIDTH(W), .BLOCK(BK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Golden model: plain (W+1)-bit arithmetic, overflow by the signed formula.
    function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic is);
        res_t         m;
        logic [W-1:0] bp;
        logic [W:0]   s;
        bp  = is ? ~ib : ib;
        s   = {1'b0, ia} + {1'b0, bp} + (W+1)'(is ? 1'b1 : ic);
        m.r = s[W-1:0];
        m.c = s[W];
        m.o = (ia[W-1] ^ m.r[W-1]) & (bp[W-1] ^ m.r[W-1]);
        return m;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = '0;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b0, {(W-1){1'b1}}};
            default: for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
        endcase
        return v;
    endfunction

    function automatic void clear_sb();
        exp_q.delete();
        got_q.delete();
        acc_cyc_q.delete();
        lat_q.delete();
    endfunction

    // One clock cycle, entered and left at a falling edge; records handshakes and results.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is, input logic ordy, output obs_t o);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        o.acc  = in_valid && in_ready;
        o.ret  = out_valid && out_ready;
        o.irdy = in_ready;
        o.ov   = out_valid;
        o.r    = r;
        o.c    = cout;
        o.o    = overflow;
        if (o.ret) begin
            got_q.push_back({r, cout, overflow});
            if (acc_cyc_q.size() > 0) lat_q.push_back(cyc - acc_cyc_q.pop_front());
            else lat_q.push_back(-1);
        end
        if (o.acc) begin
            exp_q.push_back(model(ia, ib, ic, is));
            acc_cyc_q.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        obs_t o;
        for (int i = 0; i < max_cycles && got_q.size() < exp_q.size(); i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, o);
    endtask

    task automatic test_reset();
        obs_t o;
        int   rets;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, r, cout, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b r=%h c=%b o=%b, expected all 0", out_valid, r, cout, overflow);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(negedge clk);
        clear_sb();
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(32'h1234_5671 + i), W'(32'h0F0F_0F0F), 1'b1, 1'b0, 1'b1, o);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, r, cout, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream: got ov=%b r=%h c=%b o=%b, expected all 0", out_valid, r, cout, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        rets = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, o);
            if (o.ov) rets++;
        end
        n_checks++;
        if (rets !== 0) begin
            n_fail++;
            $display("FAIL reset_stale: got %0d results after reset, expected 0", rets);
        end
        n_checks++;
        if (o.irdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b, expected 1", o.irdy);
        end
    endtask

    task automatic test_basic_add();
        obs_t o;
        clear_sb();
        cycle(1'b1, W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 1'b0, 1'b1, o);
        drain(20);
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results, expected 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== {W'(32'h0000_0100), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_result: got r=%h c=%b o=%b, expected r=00000100 c=0 o=0",
                         got_q[0].r, got_q[0].c, got_q[0].o);
            end
            n_checks++;
            if (lat_q[0] !== NS) begin
                n_fail++;
                $display("FAIL basic_latency: got %0d, expected %0d", lat_q[0], NS);
            end
        end
    endtask

    task automatic run_directed(input string name, input logic [W-1:0] ta[2], input logic [W-1:0] tb[2],
                                input logic tc[2], input logic ts[2], input res_t te[2]);
        obs_t o;
        clear_sb();
        for (int i = 0; i < 2; i++) cycle(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, o);
        drain(20);
        n_checks++;
        if (got_q.size() !== 2) begin
            n_fail++;
            $display("FAIL %s_count: got %0d results, expected 2", name, got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_q[i] !== te[i]) begin
                    n_fail++;
                    $display("FAIL %s_%0d: got r=%h c=%b o=%b, expected r=%h c=%b o=%b", name, i,
                             got_q[i].r, got_q[i].c, got_q[i].o, te[i].r, te[i].c, te[i].o);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] ta[2] = '{W'(32'hFFFF_FFFF), W'(32'h7FFF_FFFF)};
        logic [W-1:0] tb[2] = '{W'(32'h0), W'(32'h1)};
        logic         tc[2] = '{1'b1, 1'b0};
        logic         ts[2] = '{1'b0, 1'b0};
        res_t         te[2] = '{{W'(32'h0), 1'b1, 1'b0}, {W'(32'h8000_0000), 1'b0, 1'b1}};
        run_directed("bypass", ta, tb, tc, ts, te);
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta[2] = '{W'(32'h5), W'(32'h8000_0000)};
        logic [W-1:0] tb[2] = '{W'(32'h7), W'(32'h1)};
        logic         tc[2] = '{1'b0, 1'b1};
        logic         ts[2] = '{1'b1, 1'b1};
        res_t         te[2] = '{{W'(32'hFFFF_FFFE), 1'b0, 1'b0}, {W'(32'h7FFF_FFFF), 1'b1, 1'b1}};
        run_directed("subtract", ta, tb, tc, ts, te);
    endtask

    task automatic test_back_to_back();
        obs_t         o;
        logic [W-1:0] opa[10];
        logic [W-1:0] opb[10];
        res_t         snap;
        int           idx;
        clear_sb();
        for (int i = 0; i < 10; i++) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
        end
        idx  = 0;
        snap = '0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            cycle(1'b1, opa[idx], opb[idx], idx[0], idx[1], !(c >= 6 && c < 11), o);
            if (o.acc) idx++;
            if (c == 6) snap = {o.r, o.c, o.o};
            if (c >= 6 && c < 11) begin
                n_checks++;
                if (o.irdy !== 1'b0 || o.ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_ready_c%0d: got in_ready=%b out_valid=%b, expected 0 1", c, o.irdy, o.ov);
                end
                n_checks++;
                if ({o.r, o.c, o.o} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_frozen_c%0d: got r=%h c=%b o=%b, expected r=%h c=%b o=%b", c,
                             o.r, o.c, o.o, snap.r, snap.c, snap.o);
                end
            end
        end
        drain(40);
        n_checks++;
        if (got_q.size() !== 10 || exp_q.size() !== 10) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results / %0d accepted, expected 10 / 10", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL stall_result_%0d: got r=%h c=%b o=%b, expected r=%h c=%b o=%b", i,
                             got_q[i].r, got_q[i].c, got_q[i].o, exp_q[i].r, exp_q[i].c, exp_q[i].o);
                end
            end
        end
    endtask

    task automatic test_random();
        obs_t         o;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           sent;
        clear_sb();
        sent = 0;
        ra = rand_op(); rb = rand_op(); rc = 1'($urandom); rs = 1'($urandom);
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            cycle($urandom_range(0, 3) != 0, ra, rb, rc, rs, $urandom_range(0, 3) != 0, o);
            if (o.acc) begin
                sent++;
                ra = rand_op(); rb = rand_op(); rc = 1'($urandom); rs = 1'($urandom);
            end
        end
        drain(40);
        n_checks++;
        if (sent !== 10000 || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d results / %0d sent, expected %0d / 10000",
                     got_q.size(), sent, exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_result_%0d: got r=%h c=%b o=%b, expected r=%h c=%b o=%b", i,
                             got_q[i].r, got_q[i].c, got_q[i].o, exp_q[i].r, exp_q[i].c, exp_q[i].o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_bypass();
        test_subtract();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cbya_adder.md
# pipelined_cbya_adder

Parametrised, pipelined carry-bypass adder/subtractor: the next generation of the fixed 32-bit, four-block carry-bypass adder. WIDTH is split into WIDTH/BLOCK carry-bypass slices. One slice is evaluated per pipeline stage, with the inter-slice carry registered, so clock frequency is set by one BLOCK-bit slice and not by the full width. Supports add/subtract mode, external carry-in, valid/ready flow control with full-pipeline stall, and per-result carry-out and signed overflow.

## Interface
- WIDTH, 32, operand/result width. Must be a multiple of BLOCK.
- BLOCK, 8, bits per carry-bypass slice, ≥2. NSTAGES = WIDTH/BLOCK.
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: r=a+b+cin; 1: r=a-b (a+~b+1)
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  downstream accepts result
- r  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB. For sub, 1 = no borrow.
- overflow  output  1  signed overflow: (a[W-1]^r[W-1]) & (b'[W-1]^r[W-1]), where b' = b or ~b per sub

## Operation
- Accept when in_valid && in_ready. Before it is registered in stage 0: b' = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NSTAGES-1) holds:
  - valid bit
  - remaining unsummed a, b' slices
  - result slices 0..k
  - carry out of slice k
  - a[MSB], b'[MSB] for overflow
- Slice logic per stage:
  - P = &(a_s ^ b'_s)
  - ripple sum of the BLOCK bits with incoming carry
  - slice carry-out = P ? carry-in : ripple carry-out
  - The result must be bit-identical to a plain WIDTH-bit ripple add.
- Stage k computes slice k combinationally from stage k-1 registers (stage 0 from inputs) and registers it on an enable edge.
- The last stage's registers drive r, cout, overflow and out_valid directly. Outputs are registered with no combinational path from inputs.
- Global enable: en = !out_valid || out_ready.
  - in_ready = en.
  - When en=0, every stage holds, including valid bits.
  - When en=1, all stages advance together. A stage with no input valid loads valid=0 (bubble).
- Results leave in acceptance order. No reordering, no dropping, no duplication.
- Reset (asserted at any time, including mid-stream):
  - Immediately clears all stage valid bits, r=0, cout=0, overflow=0, out_valid=0.
  - In-flight operations are discarded.
  - in_ready=1 once rst deasserts.
- Data registers of invalid stages are don't-care internally, but r/cout/overflow must remain at their last valid values (or 0 after reset) while out_valid=0.

## Timing
- Latency NSTAGES cycles:
  - accepted at end of cycle t → out_valid=1 in cycle t+NSTAGES when no stall occurs;
  - each stalled cycle adds one.
- Throughput: one operation per cycle while out_ready=1.
- out_valid, r, cout, overflow are stable while out_valid && !out_ready.
- Back-pressure: in_ready drops in the same cycle out_valid && !out_ready. No skid buffer. Up to NSTAGES results are in flight.
- Simultaneous out_ready=1 with in_valid=1 while full: the result retires and the new operation enters on the same edge.
- NSTAGES=1 (BLOCK=WIDTH) is legal and gives latency 1.
- Critical path: one BLOCK-bit ripple plus bypass mux plus register setup.

## Test plan
- Reset/idle: assert rst mid-stream with 3 ops in flight → out_valid=0, r=0, cout=0, overflow=0 immediately. No stale results emerge after release. in_ready=1.
- Basic add, WIDTH=32/BLOCK=8: a=0x0000_00FF, b=0x0000_0001, cin=0 → r=0x0000_0100, cout=0, overflow=0, out_valid exactly 4 cycles after acceptance.
- Full bypass chain: a=0xFFFF_FFFF, b=0, cin=1 → r=0, cout=1, overflow=0. Then a=0x7FFF_FFFF, b=1 → r=0x8000_0000, overflow=1, cout=0.
- Subtract: a=5, b=7, sub=1 → r=0xFFFF_FFFE, cout=0. Then a=0x8000_0000, b=1, sub=1 → r=0x7FFF_FFFF, overflow=1, cout=1.
- Back-pressure: stream 10 ops back-to-back, hold out_ready=0 for 5 cycles mid-stream → in_ready low those cycles, outputs frozen, all 10 results in order, none lost.
- Random regression at WIDTH∈{8,32,64}, BLOCK∈{4,8,WIDTH}: ≥10k random a/b/cin/sub with random valid/ready against a golden {cout,r}=a+b'+c0 model. Overflow is checked by formula.
